voice_phase_engine: RTL and testbench

// Parametrised successor to the per-voice phase_incr PIO array: one Avalon-MM slave holds NUM_VOICES

---
 rtl/voice_pkg.sv | 25 ++
 rtl/voice_wave_gen.sv | 33 +++
 rtl/voice_phase_engine.sv | 168 ++++++++++++++++
 tb/tb_voice_phase_engine.sv | 379 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/voice_pkg.sv
// Shared types and register-map constants for the voice phase engine.
package voice_pkg;

  typedef enum logic [1:0] {
    MODE_SAW    = 2'd0,
    MODE_SQUARE = 2'd1,
    MODE_TRI    = 2'd2,
    MODE_SILENT = 2'd3
  } mode_t;

  localparam logic [1:0] REG_INCR   = 2'd0;
  localparam logic [1:0] REG_CTRL   = 2'd1;
  localparam logic [1:0] REG_STATUS = 2'd2;

  localparam int STAT_BUSY    = 0;
  localparam int STAT_OVERRUN = 1;
  localparam int CTRL_GATE    = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2
  } fsm_state_t;

endpackage

// File: rtl/voice_wave_gen.sv
// Combinational oscillator shaper: maps a phase accumulator value and a mode
// to one signed sample.
module voice_wave_gen
  import voice_pkg::*;
#(
  parameter int PHASE_W  = 32,
  parameter int SAMPLE_W = 16
) (
  input  logic [PHASE_W-1:0]         phase,
  input  logic [1:0]                 mode,
  output logic signed [SAMPLE_W-1:0] wave
);

  localparam logic signed [SAMPLE_W-1:0] SQ_MAX = {1'b0, {(SAMPLE_W-1){1'b1}}};

  logic [SAMPLE_W-1:0] u;
  logic [SAMPLE_W-1:0] t;

  always_comb begin
    u = phase[PHASE_W-1 -: SAMPLE_W];
    // Triangle folds the lower phase window back on itself, then recentres.
    t = phase[PHASE_W-2 -: SAMPLE_W];
    if (t[SAMPLE_W-1]) t = ~t;
    t[SAMPLE_W-1] = ~t[SAMPLE_W-1];
    case (mode_t'(mode))
      MODE_SAW:    wave = signed'({~u[SAMPLE_W-1], u[SAMPLE_W-2:0]});
      MODE_SQUARE: wave = phase[PHASE_W-1] ? -SQ_MAX : SQ_MAX;
      MODE_TRI:    wave = signed'(t);
      default:     wave = '0;
    endcase
  end

endmodule

// File: rtl/voice_phase_engine.sv
// Avalon-MM register file of per-voice increments/controls plus a
// time-multiplexed engine that advances all phases once per sample tick and mixes them.
module voice_phase_engine
  import voice_pkg::*;
#(
  parameter int NUM_VOICES = 32,
  parameter int PHASE_W    = 32,
  parameter int SAMPLE_W   = 16
) (
  input  logic                            clk_clk,
  input  logic                            reset_reset_n,
  input  logic [$clog2(NUM_VOICES)+1:0]   avs_address,
  input  logic                            avs_write,
  input  logic [31:0]                     avs_writedata,
  input  logic                            avs_read,
  output logic [31:0]                     avs_readdata,
  input  logic                            sample_tick,
  output logic [SAMPLE_W-1:0]             sample_data,
  output logic                            sample_valid,
  input  logic                            sample_ready,
  output logic                            busy
);

  localparam int VW    = $clog2(NUM_VOICES);
  localparam int ACC_W = SAMPLE_W + VW;

  // Average over all voices: arithmetic shift by VW, keep SAMPLE_W bits.
  function automatic logic [SAMPLE_W-1:0] mix_scale(input logic signed [ACC_W-1:0] sum);
    return sum[ACC_W-1:VW];
  endfunction

  logic [PHASE_W-1:0] incr   [NUM_VOICES];
  logic [PHASE_W-1:0] phase  [NUM_VOICES];
  logic [1:0]         mode_r [NUM_VOICES];
  logic               gate_r [NUM_VOICES];

  fsm_state_t state, state_nxt;
  logic [VW-1:0]            v_cnt;
  logic signed [ACC_W-1:0]  acc;
  logic                     overrun;

  logic [1:0]    region;
  logic [VW-1:0] idx;
  logic          wr_incr, wr_ctrl, wr_stat;
  logic          tick_accept, overrun_set, last_voice;
  logic [31:0]   rd_mux;

  logic [PHASE_W-1:0]          new_phase;
  logic signed [SAMPLE_W-1:0]  wave;
  logic signed [ACC_W-1:0]     contrib_ext;
  logic signed [ACC_W-1:0]     acc_sum;

  assign region  = avs_address[VW+1:VW];
  assign idx     = avs_address[VW-1:0];
  assign wr_incr = avs_write && (region == REG_INCR);
  assign wr_ctrl = avs_write && (region == REG_CTRL);
  assign wr_stat = avs_write && (region == REG_STATUS);
  assign busy    = (state == ST_RUN);

  // A tick is only taken when the engine is idle and nothing is awaiting the consumer.
  assign tick_accept = sample_tick && (state == ST_IDLE) && !sample_valid;
  assign overrun_set = sample_tick && !tick_accept;
  assign last_voice  = (v_cnt == VW'(NUM_VOICES - 1));

  // Engine stage: current voice's advanced phase, its waveform and running sum.
  assign new_phase = phase[v_cnt] + incr[v_cnt];

  voice_wave_gen #(
    .PHASE_W  (PHASE_W),
    .SAMPLE_W (SAMPLE_W)
  ) u_wave (
    .phase (new_phase),
    .mode  (mode_r[v_cnt]),
    .wave  (wave)
  );

  always_comb begin
    contrib_ext = '0;
    if (state == ST_RUN && gate_r[v_cnt]) contrib_ext = {{VW{wave[SAMPLE_W-1]}}, wave};
    acc_sum = acc + contrib_ext;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (tick_accept) state_nxt = ST_RUN;
      ST_RUN:  if (last_voice) state_nxt = ST_HOLD;
      ST_HOLD: if (sample_valid && sample_ready) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    rd_mux = '0;
    case (region)
      REG_INCR: rd_mux[PHASE_W-1:0] = incr[idx];
      REG_CTRL: begin
        rd_mux[1:0]       = mode_r[idx];
        rd_mux[CTRL_GATE] = gate_r[idx];
      end
      REG_STATUS: begin
        rd_mux[STAT_BUSY]    = busy;
        rd_mux[STAT_OVERRUN] = overrun;
      end
      default: rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state        <= ST_IDLE;
      v_cnt        <= '0;
      acc          <= '0;
      sample_data  <= '0;
      sample_valid <= 1'b0;
      overrun      <= 1'b0;
      avs_readdata <= '0;
    end else begin
      state <= state_nxt;
      // A fresh overrun outranks a simultaneous W1C.
      overrun <= overrun_set | (overrun & ~(wr_stat & avs_writedata[STAT_OVERRUN]));
      if (avs_read) avs_readdata <= rd_mux;
      case (state)
        ST_IDLE: begin
          if (tick_accept) begin
            v_cnt <= '0;
            acc   <= '0;
          end
        end
        ST_RUN: begin
          v_cnt <= v_cnt + 1'b1;
          acc   <= acc_sum;
          if (last_voice) begin
            sample_data  <= mix_scale(acc_sum);
            sample_valid <= 1'b1;
          end
        end
        ST_HOLD: if (sample_ready) sample_valid <= 1'b0;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      for (int i = 0; i < NUM_VOICES; i++) begin
        incr[i]   <= '0;
        phase[i]  <= '0;
        mode_r[i] <= MODE_SAW;
        gate_r[i] <= 1'b0;
      end
    end else begin
      for (int i = 0; i < NUM_VOICES; i++) begin
        if (wr_incr && idx == VW'(i)) incr[i] <= avs_writedata[PHASE_W-1:0];
        if (wr_ctrl && idx == VW'(i)) begin
          mode_r[i] <= avs_writedata[1:0];
          gate_r[i] <= avs_writedata[CTRL_GATE];
        end
        // Gate rising edge restarts the voice, even if the engine is on it this cycle.
        if (wr_ctrl && idx == VW'(i) && avs_writedata[CTRL_GATE] && !gate_r[i])
          phase[i] <= '0;
        else if (state == ST_RUN && v_cnt == VW'(i) && gate_r[i])
          phase[i] <= new_phase;
      end
    end
  end

endmodule

// File: tb/tb_voice_phase_engine.sv
// Scoreboard bench for voice_phase_engine with four voices.
module tb_voice_phase_engine;

  localparam int NV = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  avs_address = '0;
  logic        avs_write = 1'b0;
  logic [31:0] avs_writedata = '0;
  logic        avs_read = 1'b0;
  logic [31:0] avs_readdata;
  logic        sample_tick = 1'b0;
  logic [15:0] sample_data;
  logic        sample_valid;
  logic        sample_ready = 1'b0;
  logic        busy;

  int checks = 0;
  int failures = 0;

  logic [31:0] m_incr  [NV];
  logic [31:0] m_phase [NV];
  logic [31:0] m_ctrl  [NV];
  logic [15:0] exp_q [$];

  voice_phase_engine #(.NUM_VOICES(NV), .PHASE_W(32), .SAMPLE_W(16)) dut (
    .clk_clk       (clk),
    .reset_reset_n (rst_n),
    .avs_address   (avs_address),
    .avs_write     (avs_write),
    .avs_writedata (avs_writedata),
    .avs_read      (avs_read),
    .avs_readdata  (avs_readdata),
    .sample_tick   (sample_tick),
    .sample_data   (sample_data),
    .sample_valid  (sample_valid),
    .sample_ready  (sample_ready),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int model_wave(logic [31:0] ph, logic [1:0] md);
    int t;
    case (md)
      2'd0: return int'(ph[31:16]) - 32768;
      2'd1: return ph[31] ? -32767 : 32767;
      2'd2: begin
        t = int'(ph[30:15]);
        if (t >= 32768) t = 65535 - t;
        t = t ^ 32'h8000;
        return (t >= 32768) ? t - 65536 : t;
      end
      default: return 0;
    endcase
  endfunction

  function automatic logic [15:0] model_run();
    int sum = 0;
    int s;
    logic [15:0] r;
    for (int v = 0; v < NV; v++) begin
      if (m_ctrl[v][8]) begin
        m_phase[v] = m_phase[v] + m_incr[v];
        sum += model_wave(m_phase[v], m_ctrl[v][1:0]);
      end
    end
    s = sum >>> 2;
    r = s[15:0];
    return r;
  endfunction

  task automatic model_reset();
    for (int v = 0; v < NV; v++) begin
      m_incr[v] = '0;
      m_phase[v] = '0;
      m_ctrl[v] = '0;
    end
    exp_q.delete();
  endtask

  // All driving tasks start just after a negedge and return just after one.
  task automatic cpu_write(input logic [3:0] addr, input logic [31:0] data);
    avs_address = addr;
    avs_writedata = data;
    avs_write = 1'b1;
    @(negedge clk);
    avs_write = 1'b0;
  endtask

  task automatic cpu_read(input logic [3:0] addr, output logic [31:0] data);
    avs_address = addr;
    avs_read = 1'b1;
    @(negedge clk);
    avs_read = 1'b0;
    data = avs_readdata;
  endtask

  task automatic reg_write(input logic [3:0] addr, input logic [31:0] data);
    int v;
    v = int'(addr[1:0]);
    if (addr[3:2] == 2'd0) m_incr[v] = data;
    if (addr[3:2] == 2'd1) begin
      if (data[8] && !m_ctrl[v][8]) m_phase[v] = '0;
      m_ctrl[v] = data & 32'h0000_0103;
    end
    cpu_write(addr, data);
  endtask

  task automatic tick_raw();
    sample_tick = 1'b1;
    @(negedge clk);
    sample_tick = 1'b0;
  endtask

  task automatic tick_expect();
    exp_q.push_back(model_run());
    tick_raw();
  endtask

  task automatic wait_valid(input string name, output bit ok);
    int k = 0;
    while (!sample_valid && k < 40) begin
      @(negedge clk);
      k++;
    end
    ok = sample_valid;
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL %s: timeout waiting for sample_valid, got 0 need 1", name);
    end
  endtask

  task automatic consume(input string name, output logic [15:0] got);
    bit ok;
    logic [15:0] exp;
    got = 'x;
    wait_valid(name, ok);
    if (ok) begin
      got = sample_data;
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL %s: unexpected sample got %h need none", name, got);
      end else begin
        exp = exp_q.pop_front();
        if (got !== exp) begin
          failures++;
          $display("FAIL %s: sample got %h need %h", name, got, exp);
        end
      end
      sample_ready = 1'b1;
      @(negedge clk);
      sample_ready = 1'b0;
    end
  endtask

  task automatic check_all_regs_zero(input string name);
    logic [31:0] rd;
    for (int a = 0; a < 16; a++) begin
      cpu_read(4'(a), rd);
      checks++;
      if (rd !== 32'h0) begin
        failures++;
        $display("FAIL %s: reg addr %0d got %h need 00000000", name, a, rd);
      end
    end
  endtask

  task automatic test_reset();
    logic [15:0] got;
    int cyc;
    model_reset();
    check_all_regs_zero("reset_regs");
    checks++;
    if (sample_valid !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_outputs: valid=%b busy=%b need 0 0", sample_valid, busy);
    end
    exp_q.push_back(model_run());
    sample_tick = 1'b1;
    cyc = 0;
    @(negedge clk);
    sample_tick = 1'b0;
    cyc = 1;
    while (!sample_valid && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (cyc !== 5) begin
      failures++;
      $display("FAIL latency: got %0d cycles need 5", cyc);
    end
    consume("silent_sample", got);
    checks++;
    if (got !== 16'h0000) begin
      failures++;
      $display("FAIL silent_value: got %h need 0000", got);
    end
  endtask

  task automatic test_saw();
    logic [15:0] got, first;
    logic [31:0] rd;
    reg_write(4'h0, 32'h1000_0000);
    reg_write(4'h4, 32'h0000_0100);
    cpu_read(4'h0, rd);
    checks++;
    if (rd !== 32'h1000_0000) begin
      failures++;
      $display("FAIL incr_readback: got %h need 10000000", rd);
    end
    cpu_read(4'h4, rd);
    checks++;
    if (rd !== 32'h0000_0100) begin
      failures++;
      $display("FAIL ctrl_readback: got %h need 00000100", rd);
    end
    first = 'x;
    for (int n = 0; n < 17; n++) begin
      tick_expect();
      consume("saw_seq", got);
      if (n == 0) first = got;
    end
    checks++;
    if (first !== 16'hE400) begin
      failures++;
      $display("FAIL saw_first: got %h need e400", first);
    end
    checks++;
    if (got !== 16'hE400) begin
      failures++;
      $display("FAIL saw_wrap: got %h need e400", got);
    end
  endtask

  task automatic test_square();
    logic [15:0] got;
    reg_write(4'h4, 32'h0000_0101);
    tick_expect();
    consume("square_first", got);
    checks++;
    if (got !== 16'h1FFF) begin
      failures++;
      $display("FAIL square_pos: got %h need 1fff", got);
    end
    for (int n = 0; n < 8; n++) begin
      tick_expect();
      consume("square_seq", got);
    end
  endtask

  task automatic test_overrun();
    logic [15:0] got;
    logic [31:0] rd;
    bit ok;
    tick_expect();
    tick_raw();
    cpu_read(4'h8, rd);
    checks++;
    if (rd !== 32'h3) begin
      failures++;
      $display("FAIL status_run_overrun: got %h need 00000003", rd);
    end
    consume("overrun_run_sample", got);
    tick_expect();
    wait_valid("overrun_hold_wait", ok);
    tick_raw();
    cpu_read(4'h8, rd);
    checks++;
    if (rd !== 32'h2) begin
      failures++;
      $display("FAIL status_hold_overrun: got %h need 00000002", rd);
    end
    cpu_write(4'h8, 32'h2);
    cpu_read(4'h8, rd);
    checks++;
    if (rd !== 32'h0) begin
      failures++;
      $display("FAIL status_w1c: got %h need 00000000", rd);
    end
    consume("overrun_hold_sample", got);
    tick_expect();
    consume("overrun_phase_kept", got);
  endtask

  task automatic test_gate_restart();
    logic [15:0] got;
    reg_write(4'h4, 32'h0000_0001);
    tick_expect();
    // This write lands in the cycle voice 0 is being processed.
    reg_write(4'h4, 32'h0000_0101);
    consume("gate_midrun_sample", got);
    tick_expect();
    consume("gate_restart_sample", got);
    checks++;
    if (got !== 16'h1FFF) begin
      failures++;
      $display("FAIL gate_restart_first: got %h need 1fff", got);
    end
  endtask

  task automatic test_all_square_reset();
    logic [15:0] got;
    bit seen;
    for (int v = 0; v < NV; v++) begin
      reg_write(4'(v), 32'h1000_0000);
      reg_write(4'(4 + v), 32'h0000_0001);
      reg_write(4'(4 + v), 32'h0000_0101);
    end
    tick_expect();
    consume("all_square", got);
    checks++;
    if (got !== 16'h7FFF) begin
      failures++;
      $display("FAIL all_square_value: got %h need 7fff", got);
    end
    tick_raw();
    @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL busy_midrun: got %b need 1", busy);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || sample_valid !== 1'b0) begin
      failures++;
      $display("FAIL async_reset: busy=%b valid=%b need 0 0", busy, sample_valid);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    seen = 1'b0;
    for (int k = 0; k < NV + 4; k++) begin
      @(negedge clk);
      if (sample_valid) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      failures++;
      $display("FAIL reset_no_sample: valid seen=%b need 0", seen);
    end
    check_all_regs_zero("post_reset_regs");
  endtask

  initial begin
    model_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    test_reset();
    test_saw();
    test_square();
    test_overrun();
    test_gate_restart();
    test_all_square_reset();
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: got %0d pending need 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
